control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning. One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-low reset.
- ir  in  32  IR contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- mem_rdy  in  1  memory completion strobe.
- src_oh  out  24  one-hot bus-source select in encoder bit order: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C.
- reg_en  out  16  R0-R15 write enables.
- hi_en, lo_en, y_en, z_en, ir_en, mar_en, mdr_en  out  1 each  special-register enables.
- inc_pc, read, write  out  1 each  PC increment; MDR load from memory; memory write.
- alu_op  out  5  ALU opcode.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- run  out  1  low only in HALT.

Function
REQ-002 States SHALL be T0-T7 and HALT; all outputs SHALL be decoded from the state and the latched ir (Moore outputs).
REQ-003 T0 SHALL assert src_oh[20], mar_en and inc_pc.
REQ-004 T1 SHALL assert read and mdr_en, and SHALL hold T1 until mem_rdy=1; it advances on the edge where mem_rdy=1.
REQ-005 T2 SHALL assert src_oh[21] and ir_en.
REQ-006 For nop (11010), T2 SHALL return to T0.
REQ-007 R-type opcodes 00011-01011 SHALL sequence: T3 Rb out + y_en; T4 Rc out + alu_op=opcode + z_en; T5 ZLow out + reg_en[Ra]; then T0.
REQ-008 addi/andi/ori (01100/01101/01110) SHALL follow REQ-007 with src_oh[23] replacing Rc in T4, and alu_op mapped to 00011/01010/01011 respectively.
REQ-009 ldi (00001) SHALL follow the REQ-008 path with alu_op=00011.
REQ-010 ld (00000) SHALL sequence: T3-T4 as ldi; T5 ZLow out + mar_en; T6 read + mdr_en, held until mem_rdy; T7 MDR out + reg_en[Ra]; then T0.
REQ-011 st (00010) SHALL sequence: T3-T5 as ld; T6 Ra out + mdr_en with read=0; T7 write, held until mem_rdy; then T0.
REQ-012 halt (11011) SHALL go from T2 to HALT; HALT SHALL drive all outputs 0 and run=0, and is left only via reset.
REQ-013 Any other opcode SHALL pulse illegal for 1 cycle in T3 and return to T0.
REQ-014 At most one src_oh bit SHALL be high in any cycle, and write and read SHALL never be high together.
REQ-015 alu_op SHALL be 0 in every state except T4.

Reset
REQ-016 Any clock edge with clr=0 SHALL force T0 and abort any memory wait.
REQ-017 While clr=0, all outputs SHALL be 0 except run=1.
REQ-018 The first T0 SHALL occur on the first edge after clr returns to 1.

Configuration
REQ-019 With CU_MULDIV_EN defined, mul (01111)/div (10000) SHALL sequence: T3 Ra out + y_en; T4 Rb out + alu_op + z_en; T5 ZLow out + lo_en; T6 ZHigh out + hi_en; then T0.
REQ-020 Without CU_MULDIV_EN, mul/div SHALL be handled as illegal per REQ-013.

Structure
REQ-021 The package cpu_pkg SHALL hold the opcode constants, the state enum and the bus-source index constants.
REQ-022 One combinational sub-module, instr_class_decode, SHALL classify the opcode into {rtype, imm, ld, ldi, st, muldiv, nop, halt, illegal}.

Verification
REQ-023 ir=0x19A20000 (add R3,R4,R4) with mem_rdy=1 -> T0..T5 in 6 cycles; T5 shows src_oh=bit19 and reg_en=0x0008.
REQ-024 T1 with mem_rdy held low for 3 cycles -> stays in T1 for 4 cycles total, and ir_en fires exactly once.
REQ-025 st R1 (opcode 00010), mem_rdy low 2 cycles in T7 -> write stays high 3 cycles, and read stays 0.
REQ-026 clr=0 asserted during ld T6 -> T0 on the next edge, all enables 0, run=1.
REQ-027 Opcode 11111 -> illegal high exactly 1 cycle, then T0.
REQ-028 halt -> run=0 held for 20 cycles; clr pulse -> T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU codes,
// bus-source indices, sequencer states and instruction classes.
package cpu_pkg;

  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_LDI   = 5'b00001;
  localparam logic [4:0] OP_ST    = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_RLAST = 5'b01011;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_ANDI  = 5'b01101;
  localparam logic [4:0] OP_ORI   = 5'b01110;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_NOP   = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;

  // Bus-source indices above the sixteen general registers
  localparam logic [4:0] SRC_ZHI = 5'd18;
  localparam logic [4:0] SRC_ZLO = 5'd19;
  localparam logic [4:0] SRC_PC  = 5'd20;
  localparam logic [4:0] SRC_MDR = 5'd21;
  localparam logic [4:0] SRC_C   = 5'd23;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    IC_RTYPE, IC_IMM, IC_LD, IC_LDI, IC_ST, IC_MULDIV, IC_NOP, IC_HALT, IC_ILLEGAL
  } iclass_t;

  // Immediate forms reuse the register-form ALU codes
  function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier feeding the control sequencer.
// mul/div are recognised only when CU_MULDIV_EN is defined.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = IC_ILLEGAL;
    if (opcode >= OP_ADD && opcode <= OP_RLAST) begin
      iclass = IC_RTYPE;
    end else begin
      case (opcode)
        OP_LD:                     iclass = IC_LD;
        OP_LDI:                    iclass = IC_LDI;
        OP_ST:                     iclass = IC_ST;
        OP_ADDI, OP_ANDI, OP_ORI:  iclass = IC_IMM;
        OP_NOP:                    iclass = IC_NOP;
        OP_HALT:                   iclass = IC_HALT;
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV:            iclass = IC_MULDIV;
`endif
        default:                   iclass = IC_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, execute T3-T7, HALT; Moore outputs.
// Define CU_MULDIV_EN to enable the mul/div execute sequence.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [23:0] src_oh,
  output logic [15:0] reg_en,
  output logic        hi_en,
  output logic        lo_en,
  output logic        y_en,
  output logic        z_en,
  output logic        ir_en,
  output logic        mar_en,
  output logic        mdr_en,
  output logic        inc_pc,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic        illegal,
  output logic        run
);

  state_t     r_state, w_next;
  logic       r_armed;
  iclass_t    w_iclass;
  logic [4:0] w_opc, w_ra, w_rb, w_rc;
  logic       w_active, w_src_vld, w_reg_wr;
  logic [4:0] w_src_idx, w_alu;
  logic       w_hi, w_lo, w_y, w_z, w_ir, w_mar, w_mdr;
  logic       w_inc, w_rd, w_wr, w_ill, w_run;
  logic       w_unused_ir;

  assign w_opc       = ir[31:27];
  assign w_ra        = {1'b0, ir[26:23]};
  assign w_rb        = {1'b0, ir[22:19]};
  assign w_rc        = {1'b0, ir[18:15]};
  assign w_unused_ir = ^ir[14:0];

  instr_class_decode u_decode (
    .opcode (w_opc),
    .iclass (w_iclass)
  );

  // r_armed holds the FSM idle for one edge after reset releases
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= ST_T0;
      r_armed <= 1'b0;
    end else if (!r_armed) begin
      r_armed <= 1'b1;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_src_vld = 1'b0;
    w_src_idx = 5'd0;
    w_reg_wr  = 1'b0;
    w_alu     = 5'd0;
    w_hi = 1'b0; w_lo = 1'b0; w_y = 1'b0; w_z = 1'b0;
    w_ir = 1'b0; w_mar = 1'b0; w_mdr = 1'b0;
    w_inc = 1'b0; w_rd = 1'b0; w_wr = 1'b0; w_ill = 1'b0;
    w_run = 1'b1;
    case (r_state)
      ST_T0: begin
        w_src_vld = 1'b1; w_src_idx = SRC_PC; w_mar = 1'b1; w_inc = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        w_rd = 1'b1; w_mdr = 1'b1;
        if (mem_rdy) w_next = ST_T2;
      end
      ST_T2: begin
        w_src_vld = 1'b1; w_src_idx = SRC_MDR; w_ir = 1'b1;
        case (w_iclass)
          IC_NOP:  w_next = ST_T0;
          IC_HALT: w_next = ST_HALT;
          default: w_next = ST_T3;
        endcase
      end
      ST_T3: begin
        w_next = ST_T4;
        case (w_iclass)
          IC_RTYPE, IC_IMM, IC_LDI, IC_LD, IC_ST: begin
            w_src_vld = 1'b1; w_src_idx = w_rb; w_y = 1'b1;
          end
          IC_MULDIV: begin
            w_src_vld = 1'b1; w_src_idx = w_ra; w_y = 1'b1;
          end
          default: begin
            w_ill = 1'b1; w_next = ST_T0;
          end
        endcase
      end
      ST_T4: begin
        w_src_vld = 1'b1; w_z = 1'b1; w_next = ST_T5;
        case (w_iclass)
          IC_RTYPE:      begin w_src_idx = w_rc;  w_alu = w_opc;             end
          IC_IMM:        begin w_src_idx = SRC_C; w_alu = imm_alu_op(w_opc); end
          IC_MULDIV:     begin w_src_idx = w_rb;  w_alu = w_opc;             end
          IC_LDI, IC_LD, IC_ST: begin w_src_idx = SRC_C; w_alu = ALU_ADD;    end
          default: begin
            w_src_vld = 1'b0; w_z = 1'b0; w_next = ST_T0;
          end
        endcase
      end
      ST_T5: begin
        w_src_vld = 1'b1; w_src_idx = SRC_ZLO;
        case (w_iclass)
          IC_RTYPE, IC_IMM, IC_LDI: begin w_reg_wr = 1'b1; w_next = ST_T0; end
          IC_LD, IC_ST:             begin w_mar = 1'b1;    w_next = ST_T6; end
          IC_MULDIV:                begin w_lo = 1'b1;     w_next = ST_T6; end
          default:                  begin w_src_vld = 1'b0; w_next = ST_T0; end
        endcase
      end
      ST_T6: begin
        w_next = ST_T0;
        case (w_iclass)
          IC_LD: begin
            w_rd = 1'b1; w_mdr = 1'b1;
            w_next = mem_rdy ? ST_T7 : ST_T6;
          end
          IC_ST: begin
            w_src_vld = 1'b1; w_src_idx = w_ra; w_mdr = 1'b1; w_next = ST_T7;
          end
          IC_MULDIV: begin
            w_src_vld = 1'b1; w_src_idx = SRC_ZHI; w_hi = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        w_next = ST_T0;
        case (w_iclass)
          IC_LD: begin
            w_src_vld = 1'b1; w_src_idx = SRC_MDR; w_reg_wr = 1'b1;
          end
          IC_ST: begin
            w_wr = 1'b1;
            if (!mem_rdy) w_next = ST_T7;
          end
          default: ;
        endcase
      end
      ST_HALT: w_run = 1'b0;
      default: w_next = ST_T0;
    endcase
  end

  // Outputs are forced quiet while reset is held or not yet released
  assign w_active = clr && r_armed;

  for (genvar gi = 0; gi < 24; gi++) begin : g_src
    assign src_oh[gi] = w_active && w_src_vld && (w_src_idx == 5'(gi));
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_reg
    assign reg_en[gi] = w_active && w_reg_wr && (w_ra[3:0] == 4'(gi));
  end

  assign hi_en   = w_active && w_hi;
  assign lo_en   = w_active && w_lo;
  assign y_en    = w_active && w_y;
  assign z_en    = w_active && w_z;
  assign ir_en   = w_active && w_ir;
  assign mar_en  = w_active && w_mar;
  assign mdr_en  = w_active && w_mdr;
  assign inc_pc  = w_active && w_inc;
  assign read    = w_active && w_rd;
  assign write   = w_active && w_wr;
  assign illegal = w_active && w_ill;
  assign alu_op  = w_active ? w_alu : 5'd0;
  assign run     = w_active ? w_run : 1'b1;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a micro-op list reference model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        mem_rdy;
  logic [23:0] src_oh;
  logic [15:0] reg_en;
  logic        hi_en, lo_en, y_en, z_en, ir_en, mar_en, mdr_en;
  logic        inc_pc, read, write, illegal, run;
  logic [4:0]  alu_op;

  int n_vec = 0;
  int n_err = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
    .src_oh(src_oh), .reg_en(reg_en),
    .hi_en(hi_en), .lo_en(lo_en), .y_en(y_en), .z_en(z_en),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
    .inc_pc(inc_pc), .read(read), .write(write),
    .alu_op(alu_op), .illegal(illegal), .run(run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] src;
    logic [15:0] reg_en;
    logic hi, lo, y, z, ir_en, mar, mdr, inc, rd, wr;
    logic [4:0] alu;
    logic ill;
    logic run;
  } ov_t;

  typedef struct packed { ov_t o; logic w; } step_t;
  typedef struct packed { step_t [7:0] s; logic [3:0] n; logic h; } plan_t;

  function automatic ov_t idle();
    ov_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic logic [23:0] bus(input int i);
    return 24'd1 << i;
  endfunction

  function automatic plan_t push(input plan_t p, input ov_t o, input logic w);
    plan_t q = p;
    q.s[q.n[2:0]] = {o, w};
    q.n = q.n + 4'd1;
    return q;
  endfunction

  // Each instruction is a list of micro-operations; a step with w=1 waits for mem_rdy
  function automatic plan_t mk_plan(input logic [31:0] v);
    plan_t p;
    ov_t o;
    int op, ra, rb, rc;
    logic [4:0] ialu;
    bit is_r, is_i, is_md;
    p = '0;
    op = int'(v[31:27]); ra = int'(v[26:23]); rb = int'(v[22:19]); rc = int'(v[18:15]);
    o = idle(); o.src = bus(20); o.mar = 1'b1; o.inc = 1'b1; p = push(p, o, 1'b0);
    o = idle(); o.rd = 1'b1; o.mdr = 1'b1;                   p = push(p, o, 1'b1);
    o = idle(); o.src = bus(21); o.ir_en = 1'b1;             p = push(p, o, 1'b0);
    is_r = (op >= 3 && op <= 11);
    is_i = (op <= 2 || op == 12 || op == 13 || op == 14);
    is_md = 1'b0;
`ifdef CU_MULDIV_EN
    is_md = (op == 15 || op == 16);
`endif
    ialu = (op == 13) ? 5'd10 : (op == 14) ? 5'd11 : 5'd3;
    if (op == 26) begin
    end else if (op == 27) begin
      p.h = 1'b1;
    end else if (is_r || is_i) begin
      o = idle(); o.src = bus(rb); o.y = 1'b1; p = push(p, o, 1'b0);
      o = idle(); o.src = is_r ? bus(rc) : bus(23);
      o.alu = is_r ? v[31:27] : ialu; o.z = 1'b1; p = push(p, o, 1'b0);
      o = idle(); o.src = bus(19);
      if (op == 0 || op == 2) o.mar = 1'b1; else o.reg_en = 16'd1 << ra;
      p = push(p, o, 1'b0);
      if (op == 0) begin
        o = idle(); o.rd = 1'b1; o.mdr = 1'b1;          p = push(p, o, 1'b1);
        o = idle(); o.src = bus(21); o.reg_en = 16'd1 << ra; p = push(p, o, 1'b0);
      end
      if (op == 2) begin
        o = idle(); o.src = bus(ra); o.mdr = 1'b1; p = push(p, o, 1'b0);
        o = idle(); o.wr = 1'b1;                   p = push(p, o, 1'b1);
      end
    end else if (is_md) begin
      o = idle(); o.src = bus(ra); o.y = 1'b1;                      p = push(p, o, 1'b0);
      o = idle(); o.src = bus(rb); o.alu = v[31:27]; o.z = 1'b1;    p = push(p, o, 1'b0);
      o = idle(); o.src = bus(19); o.lo = 1'b1;                     p = push(p, o, 1'b0);
      o = idle(); o.src = bus(18); o.hi = 1'b1;                     p = push(p, o, 1'b0);
    end else begin
      o = idle(); o.ill = 1'b1; p = push(p, o, 1'b0);
    end
    return p;
  endfunction

  plan_t      cur_plan;
  logic [3:0] m_pos = 4'd0;
  logic       m_armed = 1'b0;
  logic       m_halt = 1'b0;

  always_comb cur_plan = mk_plan(ir);

  always @(posedge clk) begin
    if (!clr) begin
      m_armed <= 1'b0; m_halt <= 1'b0; m_pos <= 4'd0;
    end else if (!m_armed) begin
      m_armed <= 1'b1; m_pos <= 4'd0;
    end else if (!m_halt) begin
      if (cur_plan.s[m_pos[2:0]].w && !mem_rdy) m_pos <= m_pos;
      else if (m_pos == cur_plan.n - 4'd1) begin
        m_pos  <= 4'd0;
        m_halt <= cur_plan.h;
      end else m_pos <= m_pos + 4'd1;
    end
  end

  function automatic ov_t exp_now();
    if (!clr || !m_armed) return idle();
    if (m_halt) return '0;
    return cur_plan.s[m_pos[2:0]].o;
  endfunction

  // Cycle-by-cycle comparison against the model
  initial begin
    ov_t a, e;
    forever begin
      @(posedge clk); #2;
      e = exp_now();
      a = {src_oh, reg_en, hi_en, lo_en, y_en, z_en, ir_en, mar_en, mdr_en,
           inc_pc, read, write, alu_op, illegal, run};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle@%0t: outputs %h, expected %h", $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Holds reset two cycles, releases it; returns at the negedge showing T0
  task automatic restart(input logic [31:0] ir_v, input logic rdy);
    @(negedge clk); clr = 1'b0;
    @(negedge clk); @(negedge clk);
    ir = ir_v; mem_rdy = rdy; clr = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [31:0] IR_ADD  = 32'h19A20000;
  localparam logic [31:0] IR_ST   = {5'b00010, 4'd1, 4'd2, 4'd0, 15'd0};
  localparam logic [31:0] IR_LD   = {5'b00000, 4'd5, 4'd2, 4'd0, 15'd0};
  localparam logic [31:0] IR_BAD  = {5'b11111, 27'd0};
  localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

  initial begin
    int rd_c, ire_c, wr_c, both_c, ill_c, halt_c;
    logic [4:0] ops [15];
    clr = 1'b0; ir = 32'd0; mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_run", 32'(run), 32'd1);
    chk("rst_src", 32'(src_oh), 32'd0);
    chk("rst_inc", 32'(inc_pc), 32'd0);

    restart(IR_ADD, 1'b1);
    chk("add_t0_src", 32'(src_oh), 32'h100000);
    repeat (5) @(negedge clk);
    chk("add_t5_src", 32'(src_oh), 32'h080000);
    chk("add_t5_reg", 32'(reg_en), 32'h0008);
    @(negedge clk);
    chk("add_back_t0", 32'(src_oh), 32'h100000);
    $display("txn add R3,R4,R4 complete");

    restart(IR_ADD, 1'b0);
    rd_c = 0; ire_c = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (read) rd_c++;
      if (ir_en) ire_c++;
      mem_rdy = (rd_c >= 4);
    end
    chk("t1_wait_cycles", 32'(rd_c), 32'd4);
    chk("t1_ir_en_once", 32'(ire_c), 32'd1);
    $display("txn fetch with 3-cycle memory stall complete");

    restart(IR_ST, 1'b1);
    repeat (3) @(negedge clk);
    wr_c = 0; rd_c = 0; both_c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (write) wr_c++;
      if (read) rd_c++;
      if (read && write) both_c++;
      mem_rdy = !(write && wr_c < 3);
    end
    @(negedge clk);
    chk("st_write_cycles", 32'(wr_c), 32'd3);
    chk("st_read_zero", 32'(rd_c), 32'd0);
    chk("st_rw_overlap", 32'(both_c), 32'd0);
    chk("st_back_t0", 32'(src_oh), 32'h100000);
    $display("txn st R1 with 2-cycle write stall complete");

    restart(IR_LD, 1'b1);
    @(negedge clk);
    @(negedge clk); mem_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("ld_t6_read", 32'(read), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_reg_en", 32'(reg_en), 32'd0);
    chk("abort_mar", 32'(mar_en), 32'd0);
    chk("abort_read", 32'(read), 32'd0);
    chk("abort_src", 32'(src_oh), 32'd0);
    chk("abort_run", 32'(run), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    chk("abort_t0_src", 32'(src_oh), 32'h100000);
    chk("abort_t0_inc", 32'(inc_pc), 32'd1);
    $display("txn ld aborted by reset in T6 complete");

    restart(IR_BAD, 1'b1);
    ill_c = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (illegal) ill_c++;
      if (i == 3) chk("ill_t3", 32'(illegal), 32'd1);
    end
    chk("ill_count", 32'(ill_c), 32'd1);
    chk("ill_then_t0", 32'(src_oh), 32'h100000);
    $display("txn illegal opcode 11111 complete");

    restart(IR_HALT, 1'b1);
    repeat (3) @(negedge clk);
    halt_c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!run) halt_c++;
    end
    chk("halt_run_low", 32'(halt_c), 32'd20);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("halt_exit_src", 32'(src_oh), 32'h100000);
    chk("halt_exit_run", 32'(run), 32'd1);
    $display("txn halt then reset complete");

    ops = '{5'b00011, 5'b00100, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b00001,
            5'b00000, 5'b00010, 5'b11010, 5'b11011, 5'b01111, 5'b10000, 5'b11100, 5'b10001};
    for (int k = 0; k < 15; k++) begin
      restart({ops[k], 4'(k), 4'(k + 5), 4'(k + 9), 15'd0}, 1'b0);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        mem_rdy = (c % 3 == 2);
      end
      $display("txn sweep opcode %b complete", ops[k]);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
